// File: rtl/icache_direct_if.sv
// Fetch-side and memory-side signal bundle for icache_direct.
//   master : the environment (datapath fetch stage plus memory controller); drives fetch
//            requests, flush and memory responses, observes hit data and memory requests.
//   slave  : the cache itself.
// Signals: imemREN/imemaddr/ihit/imemload/flush (datapath), iREN/iaddr/iwait/iload (memory).
interface icache_direct_if #(
   parameter int unsigned WORD_W = 32
);
   logic              imemREN;
   logic [WORD_W-1:0] imemaddr;
   logic              ihit;
   logic [WORD_W-1:0] imemload;
   logic              flush;
   logic              iREN;
   logic [WORD_W-1:0] iaddr;
   logic              iwait;
   logic [WORD_W-1:0] iload;

   modport master (
      output imemREN, imemaddr, flush, iwait, iload,
      input  ihit, imemload, iREN, iaddr
   );

   modport slave (
      input  imemREN, imemaddr, flush, iwait, iload,
      output ihit, imemload, iREN, iaddr
   );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-block instruction cache.
// Hits return combinationally in the same cycle; a miss is serviced by a single-word fill
// through a two-state FSM (StIdle/StFetch).
// Ports:
//   CLK        clock, rising edge
//   RST        asynchronous, active-high reset
//   bus        icache_direct_if.slave (fetch port + memory instruction port)
//   hit_count  cycles with ihit = 1        (only with ICACHE_PERF_EN)
//   miss_count IDLE->FETCH transitions     (only with ICACHE_PERF_EN)
// Optional feature macro: ICACHE_PERF_EN enables the two 32-bit performance counters.
module icache_direct #(
   parameter int unsigned SETS   = 16,
   parameter int unsigned WORD_W = 32
) (
   input  logic               CLK,
   input  logic               RST,
   icache_direct_if.slave     bus
`ifdef ICACHE_PERF_EN
   ,
   output logic [31:0]        hit_count,
   output logic [31:0]        miss_count
`endif
);

   localparam int unsigned IDX   = $clog2(SETS);
   localparam int unsigned TAG_W = WORD_W - IDX - 2;

   typedef enum logic {StIdle, StFetch} state_e;

   state_e            state_q;
   logic [SETS-1:0]   valid_q;
   logic [TAG_W-1:0]  tag_q  [SETS];
   logic [WORD_W-1:0] data_q [SETS];
   logic [WORD_W-1:0] miss_addr_q;

   logic [IDX-1:0]    req_idx;
   logic [TAG_W-1:0]  req_tag;
   logic [IDX-1:0]    fill_idx;
   logic [TAG_W-1:0]  fill_tag;
   logic              hit;
   logic              miss;
   logic              fill;
   logic              unused_addr_lsb;

   assign req_idx  = bus.imemaddr[IDX+1:2];
   assign req_tag  = bus.imemaddr[WORD_W-1:IDX+2];
   assign fill_idx = miss_addr_q[IDX+1:2];
   assign fill_tag = miss_addr_q[WORD_W-1:IDX+2];

   // Byte offset within the word plays no part in lookup.
   assign unused_addr_lsb = ^bus.imemaddr[1:0];

   assign hit  = bus.imemREN & valid_q[req_idx] & (tag_q[req_idx] == req_tag) & ~bus.flush &
                 (state_q == StIdle);
   assign miss = bus.imemREN & ~hit & ~bus.flush & (state_q == StIdle);
   // flush on the return cycle discards the fill.
   assign fill = (state_q == StFetch) & ~bus.iwait & ~bus.flush;

   assign bus.ihit     = hit;
   assign bus.imemload = hit ? data_q[req_idx] : '0;
   // Decoded straight from state so an asynchronous reset drops the request at once.
   assign bus.iREN     = (state_q == StFetch);
   assign bus.iaddr    = (state_q == StFetch) ? miss_addr_q : '0;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= StIdle;
         valid_q     <= '0;
         miss_addr_q <= '0;
      end else if (bus.flush) begin
         valid_q <= '0;
         state_q <= StIdle;
      end else begin
         case (state_q)
            StIdle: begin
               if (miss) begin
                  miss_addr_q <= {bus.imemaddr[WORD_W-1:2], 2'b00};
                  state_q     <= StFetch;
               end
            end
            StFetch: begin
               if (!bus.iwait) begin
                  valid_q[fill_idx] <= 1'b1;
                  state_q           <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Tags and data are meaningless while the frame is invalid, so they carry no reset.
   always_ff @(posedge CLK) begin
      if (fill) begin
         tag_q[fill_idx]  <= fill_tag;
         data_q[fill_idx] <= bus.iload;
      end
   end

`ifdef ICACHE_PERF_EN
   logic [31:0] hit_count_q;
   logic [31:0] miss_count_q;

   // Counters survive flush; only reset clears them.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         hit_count_q  <= '0;
         miss_count_q <= '0;
      end else begin
         if (hit)  hit_count_q  <= hit_count_q + 32'd1;
         if (miss) miss_count_q <= miss_count_q + 32'd1;
      end
   end

   assign hit_count  = hit_count_q;
   assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_icache_direct.sv
module tb_icache_direct;
   localparam int unsigned Sets = 16;

   logic CLK = 1'b0;
   logic RST;

   icache_direct_if #(.WORD_W(32)) bus ();

`ifdef ICACHE_PERF_EN
   logic [31:0] hit_count;
   logic [31:0] miss_count;
`endif

   icache_direct #(.SETS(Sets), .WORD_W(32)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .bus        (bus)
`ifdef ICACHE_PERF_EN
      ,
      .hit_count  (hit_count),
      .miss_count (miss_count)
`endif
   );

   always #5 CLK = ~CLK;

   int checks   = 0;
   int failures = 0;

   // Reference model: each frame remembers which word address it holds.
   bit          m_valid [Sets];
   logic [29:0] m_word  [Sets];
   logic [31:0] m_dat   [Sets];
   bit          m_busy;
   logic [31:0] m_addr;
   logic [31:0] m_hits;
   logic [31:0] m_misses;

   function automatic logic [31:0] mem_of(input logic [31:0] a);
      if (a == 32'h40) return 32'h8C220004;
      return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction

   task automatic model_reset();
      foreach (m_valid[i]) m_valid[i] = 1'b0;
      m_busy   = 1'b0;
      m_addr   = '0;
      m_hits   = '0;
      m_misses = '0;
   endtask

   // Drive one cycle of inputs, return observed/expected {ihit, iREN, imemload, iaddr},
   // and advance the model to the state after the coming rising edge.
   task automatic step(input logic ren, input logic [31:0] addr, input logic fl,
                       input logic iw, output logic [65:0] obs, output logic [65:0] exp);
      int unsigned idx;
      bit          h;
      @(negedge CLK);
      bus.imemREN  = ren;
      bus.imemaddr = addr;
      bus.flush    = fl;
      bus.iwait    = iw;
      bus.iload    = m_busy ? mem_of(m_addr) : $urandom;
      #1;
      idx = (addr >> 2) % Sets;
      h   = ren && !fl && !m_busy && m_valid[idx] && (m_word[idx] == addr[31:2]);
      exp = {h, m_busy, (h ? m_dat[idx] : 32'h0), (m_busy ? m_addr : 32'h0)};
      obs = {bus.ihit, bus.iREN, bus.imemload, bus.iaddr};
      if (h) m_hits = m_hits + 1;
      if (fl) begin
         foreach (m_valid[i]) m_valid[i] = 1'b0;
         m_busy = 1'b0;
      end else if (m_busy) begin
         if (!iw) begin
            idx          = (m_addr >> 2) % Sets;
            m_valid[idx] = 1'b1;
            m_word[idx]  = m_addr[31:2];
            m_dat[idx]   = mem_of(m_addr);
            m_busy       = 1'b0;
         end
      end else if (ren && !h) begin
         m_busy   = 1'b1;
         m_addr   = {addr[31:2], 2'b00};
         m_misses = m_misses + 1;
      end
   endtask

   task automatic test_reset();
      logic [65:0] o, e;
      step(1'b0, 32'h0, 1'b0, 1'b1, o, e);
      checks++;
      if (o !== 66'h0) begin
         failures++;
         $display("FAIL reset_outputs: got %h want %h", o, 66'h0);
      end
      checks++;
      if (o !== e) begin
         failures++;
         $display("FAIL reset_model: got %h want %h", o, e);
      end
`ifdef ICACHE_PERF_EN
      checks++;
      if (hit_count !== 32'h0 || miss_count !== 32'h0) begin
         failures++;
         $display("FAIL reset_counters: got %h/%h want 0/0", hit_count, miss_count);
      end
`endif
   endtask

   task automatic test_cold_miss();
      logic [65:0] o, e;
      int          ren_cycles = 0;
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 32'h40, 1'b0, (i >= 1 && i <= 3), o, e);
         if (i >= 1 && i <= 4 && o[64] === 1'b1 && o[31:0] === 32'h40) ren_cycles++;
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL cold_miss cyc%0d: got %h want %h", i, o, e);
         end
      end
      checks++;
      if (o !== {1'b1, 1'b0, 32'h8C220004, 32'h0}) begin
         failures++;
         $display("FAIL cold_miss_hit: got %h want %h", o, {1'b1, 1'b0, 32'h8C220004, 32'h0});
      end
      checks++;
      if (ren_cycles != 4) begin
         failures++;
         $display("FAIL cold_miss_iren_cycles: got %0d want 4", ren_cycles);
      end
`ifdef ICACHE_PERF_EN
      checks++;
      if (miss_count !== 32'd1) begin
         failures++;
         $display("FAIL cold_miss_count: got %0d want 1", miss_count);
      end
`endif
   endtask

   task automatic test_hit_conflict();
      logic [65:0] o, e;
      logic [31:0] addrs [7] = '{32'h40, 32'h80, 32'h80, 32'h80, 32'h40, 32'h40, 32'h40};
      logic [6:0]  want_hit = 7'b1001001;  // bit i = step i
      for (int i = 0; i < 7; i++) begin
         step(1'b1, addrs[i], 1'b0, 1'b0, o, e);
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL hit_conflict cyc%0d: got %h want %h", i, o, e);
         end
         checks++;
         if (o[65] !== want_hit[i] || (i == 0 && o[64] !== 1'b0)) begin
            failures++;
            $display("FAIL hit_conflict_ihit cyc%0d: got ihit=%b iREN=%b want ihit=%b",
                     i, o[65], o[64], want_hit[i]);
         end
      end
   endtask

   task automatic test_redirect();
      logic [65:0] o, e;
      logic [31:0] addrs [7] = '{32'h100, 32'h200, 32'h200, 32'h200, 32'h200, 32'h200, 32'h200};
      logic [6:0]  iws     = 7'b0010111;  // bit i = iwait at step i
      for (int i = 0; i < 7; i++) begin
         step(1'b1, addrs[i], 1'b0, iws[i], o, e);
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL redirect cyc%0d: got %h want %h", i, o, e);
         end
         if (i >= 1 && i <= 3) begin
            checks++;
            if (o[31:0] !== 32'h100 || o[64] !== 1'b1) begin
               failures++;
               $display("FAIL redirect_iaddr cyc%0d: got %h want 00000100", i, o[31:0]);
            end
         end
         if (i == 4) begin
            checks++;
            if (o[65] !== 1'b0) begin
               failures++;
               $display("FAIL redirect_relookup: got ihit=%b want 0", o[65]);
            end
         end
         if (i == 5) begin
            checks++;
            if (o[31:0] !== 32'h200 || o[64] !== 1'b1) begin
               failures++;
               $display("FAIL redirect_new_miss: got %h want 00000200", o[31:0]);
            end
         end
      end
   endtask

   task automatic test_flush();
      logic [65:0] o, e;
      logic [31:0] addrs [10] = '{32'h40, 32'h40, 32'h40, 32'h84, 32'h84,
                                  32'h40, 32'h40, 32'h40, 32'h40, 32'h40};
      logic [9:0]  fls = 10'b0010010000;  // flush at steps 4 and 7
      for (int i = 0; i < 10; i++) begin
         step(1'b1, addrs[i], fls[i], 1'b0, o, e);
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL flush cyc%0d: got %h want %h", i, o, e);
         end
         if (i == 5 || i == 7 || i == 8) begin
            checks++;
            if (o[65] !== 1'b0 || (i == 5 && o[64] !== 1'b0)) begin
               failures++;
               $display("FAIL flush_effect cyc%0d: got ihit=%b iREN=%b want 0/0", i, o[65], o[64]);
            end
         end
      end
   endtask

   task automatic test_async_reset();
      logic [65:0] o, e;
      step(1'b1, 32'h44, 1'b0, 1'b1, o, e);
      step(1'b1, 32'h44, 1'b0, 1'b1, o, e);  // now in FETCH
      #2;
      RST = 1'b1;
      #1;
      checks++;
      if (bus.iREN !== 1'b0 || bus.ihit !== 1'b0 || bus.iaddr !== 32'h0) begin
         failures++;
         $display("FAIL async_reset: got iREN=%b ihit=%b iaddr=%h want 0/0/0",
                  bus.iREN, bus.ihit, bus.iaddr);
      end
      model_reset();
      @(negedge CLK);
      bus.imemREN = 1'b0;
      @(negedge CLK);
      RST = 1'b0;
`ifdef ICACHE_PERF_EN
      checks++;
      if (hit_count !== 32'h0 || miss_count !== 32'h0) begin
         failures++;
         $display("FAIL async_reset_counters: got %h/%h want 0/0", hit_count, miss_count);
      end
`endif
      for (int i = 0; i < 4; i++) begin
         step(1'b1, (i < 2) ? 32'h40 : 32'h200, 1'b0, 1'b0, o, e);
         checks++;
         if (o !== e || ((i == 0 || i == 2) && o[65] !== 1'b0)) begin
            failures++;
            $display("FAIL async_reset_cold cyc%0d: got %h want %h", i, o, e);
         end
      end
   endtask

   task automatic test_random();
      logic [65:0] o, e;
      logic [31:0] a;
      for (int i = 0; i < 400; i++) begin
         a = ($urandom_range(0, 2) << 6) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
         step(($urandom_range(0, 99) < 85), a, ($urandom_range(0, 99) < 3),
              $urandom_range(0, 1), o, e);
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL random cyc%0d addr=%h: got %h want %h", i, a, o, e);
         end
      end
`ifdef ICACHE_PERF_EN
      @(posedge CLK);
      #1;
      checks++;
      if (hit_count !== m_hits || miss_count !== m_misses) begin
         failures++;
         $display("FAIL random_counters: got %h/%h want %h/%h",
                  hit_count, miss_count, m_hits, m_misses);
      end
`endif
   endtask

`ifdef ICACHE_PERF_EN
   task automatic test_counter_wrap();
      logic [65:0] o, e;
      step(1'b0, 32'h0, 1'b0, 1'b0, o, e);  // let any in-flight fill finish
      step(1'b0, 32'h0, 1'b0, 1'b0, o, e);
      step(1'b1, 32'h40, 1'b0, 1'b0, o, e);
      if (o[65] !== 1'b1) begin
         step(1'b1, 32'h40, 1'b0, 1'b0, o, e);
      end
      @(posedge CLK);
      #1;
      force dut.hit_count_q = 32'hFFFFFFFF;
      #1;
      release dut.hit_count_q;
      m_hits = 32'hFFFFFFFF;
      step(1'b1, 32'h40, 1'b0, 1'b0, o, e);
      checks++;
      if (o !== e || o[65] !== 1'b1) begin
         failures++;
         $display("FAIL wrap_hit: got %h want %h", o, e);
      end
      @(posedge CLK);
      #1;
      checks++;
      if (hit_count !== 32'h0) begin
         failures++;
         $display("FAIL counter_wrap: got %h want 00000000", hit_count);
      end
   endtask
`endif

   initial begin
      RST          = 1'b1;
      bus.imemREN  = 1'b0;
      bus.imemaddr = '0;
      bus.flush    = 1'b0;
      bus.iwait    = 1'b1;
      bus.iload    = '0;
      model_reset();
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0;

      test_reset();
      test_cold_miss();
      test_hit_conflict();
      test_redirect();
      test_flush();
      test_async_reset();
      test_random();
`ifdef ICACHE_PERF_EN
      test_counter_wrap();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish want finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, one-word-per-block instruction cache.
- Sits between the pipelined datapath fetch port (imemREN/imemaddr/ihit/imemload) and the memory controller instruction port (iREN/iaddr/iwait/iload).
- Returns hits in the same cycle. Services a miss with a single-word fill through a two-state FSM.

Parameters:
- SETS, 16: number of frames; power of two, at least 2. IDX = log2(SETS).
- WORD_W, 32: data and address width.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- imemREN  in  1  datapath fetch request.
- imemaddr  in  32  datapath fetch byte address.
- ihit  out  1  fetch data valid this cycle.
- imemload  out  32  fetched instruction.
- flush  in  1  invalidate all frames.
- iREN  out  1  memory read request.
- iaddr  out  32  memory word address.
- iwait  in  1  memory busy; low means iload is valid this cycle.
- iload  in  32  memory read data.
- hit_count  out  32  present only with ICACHE_PERF_EN.
- miss_count  out  32  present only with ICACHE_PERF_EN.

Behaviour:
- Clocking and reset: one clock (CLK). Reset RST is asynchronous and active-high.
- Address split:
  - [1:0] is ignored.
  - index = [IDX+1:2].
  - tag = [31:IDX+2], which is 26 bits at the default SETS.
- Storage: per frame, valid (1 bit), tag, and data (32 bits). Only valid bits need reset. Data and tags are don't-care when the frame is invalid.
- Reset while RST is high:
  - all valid bits = 0, state = IDLE, miss_addr = 0;
  - ihit = 0, iREN = 0, iaddr = 0, imemload = 0, counters = 0;
  - RST asserted mid-FETCH drops iREN immediately, without waiting for a clock edge.
- hit = imemREN & valid[index] & (tag[index] == addr tag) & !flush & (state == IDLE).
- Combinational outputs:
  - ihit = hit.
  - imemload = data[index] when hit, else 0.
- FSM states: IDLE and FETCH.
- IDLE:
  - If imemREN & !hit & !flush: capture miss_addr = {imemaddr[31:2], 2'b00} and go to FETCH.
  - Otherwise stay in IDLE.
- FETCH:
  - iREN = 1 and iaddr = miss_addr. In IDLE, iREN = 0 and iaddr = 0.
  - When iwait = 0: write data = iload, tag, and valid = 1 at miss_addr's index, then go to IDLE.
  - ihit stays 0 for the whole of FETCH.
- Miss latency: a fetch that misses gets ihit on the cycle after the cycle in which iwait is low. That is the IDLE re-lookup. Minimum miss-to-hit is 2 cycles with zero memory wait.
- imemaddr changes during FETCH (a branch or jump redirect): the fill still completes to the latched miss_addr. The new address is looked up on return to IDLE.
- imemREN drops during FETCH: the fill still completes.
- flush:
  - At the next edge, all valid bits are cleared.
  - If in FETCH, go to IDLE, iREN drops next cycle, and the in-flight fill is discarded.
  - flush coincident with iwait = 0: flush wins and no frame is written.
  - ihit is forced to 0 during any flush cycle.
- Index collision: a fill overwrites the resident frame unconditionally. There is no write-back, because the cache is read-only.
- imemREN = 0 in IDLE: no state change, ihit = 0.

Optional Feature:
- Macro: ICACHE_PERF_EN.
- Defined:
  - hit_count increments on each cycle that ihit = 1.
  - miss_count increments on each IDLE→FETCH transition.
  - Both are 32-bit, wrap at 2^32-1→0, are cleared by RST, and are not cleared by flush.
- Undefined: the hit_count and miss_count ports and their logic are absent. All other behaviour is identical.

Test Plan:
- Cold miss:
  - Stimulus: after reset, imemREN = 1, imemaddr = 0x00000040, memory returns 0x8C220004 after iwait = 1 for 3 cycles.
  - Required: iREN = 1 with iaddr = 0x00000040 for 4 cycles; ihit = 1 with imemload = 0x8C220004 on the following cycle; miss_count = 1.
- Hit and conflict:
  - Stimulus: re-fetch 0x40, then fetch 0x80.
  - Required: 0x40 gives ihit = 1 the same cycle with no iREN. 0x80 (index 0, different tag) misses and evicts. A later fetch of 0x40 misses again.
- Redirect mid-fill:
  - Stimulus: miss on 0x100, change imemaddr to 0x200 while iwait = 1.
  - Required: iaddr holds 0x100, and frame index 0 gets 0x100's data. The next IDLE cycle issues a miss for 0x200.
- Flush:
  - Stimulus: assert flush in FETCH on the same cycle iwait = 0.
  - Required: no fill; state IDLE; iREN = 0 next cycle; the previously cached 0x40 now misses.
- Async reset:
  - Stimulus: assert RST mid-FETCH between clock edges.
  - Required: iREN = 0 and ihit = 0 immediately. After release, all fetches miss and the counters read 0.
- Counter wrap (ICACHE_PERF_EN):
  - Stimulus: force hit_count to 0xFFFFFFFF, then one hit.
  - Required: hit_count = 0.
